// File: rtl/systolic_feeder.sv
// Skews matrix A rows and matrix B columns into a systolic array, then captures its results.
// Optional drain watchdog enabled by defining SYSTOLIC_FEEDER_TIMEOUT_EN.
module systolic_feeder #(
    parameter int unsigned width_p        = 32,
    parameter int unsigned array_width_p  = 2,
    parameter int unsigned array_height_p = 2,
    parameter int unsigned k_p            = 2,
    parameter int unsigned timeout_p      = 64
) (
    input  logic                                              clk_i,
    input  logic                                              reset_i,
    input  logic [width_p*array_height_p*k_p-1:0]             a_i,
    input  logic [width_p*k_p*array_width_p-1:0]              b_i,
    input  logic                                              start_v_i,
    output logic                                              start_ready_o,
    output logic [array_height_p-1:0]                         flush_o,
    output logic [width_p*array_height_p-1:0]                 row_o,
    output logic [array_height_p-1:0]                         row_v_o,
    input  logic [array_height_p-1:0]                         row_ready_i,
    output logic [width_p*array_width_p-1:0]                  col_o,
    output logic [array_width_p-1:0]                          col_v_o,
    input  logic [array_width_p-1:0]                          col_ready_i,
    input  logic [width_p*array_height_p*array_width_p-1:0]   z_i,
    input  logic [array_height_p*array_width_p-1:0]           z_v_i,
    output logic [array_height_p*array_width_p-1:0]           z_yumi_o,
    output logic [width_p*array_height_p*array_width_p-1:0]   result_o,
    output logic                                              done_v_o,
    input  logic                                              done_yumi_i,
    output logic                                              error_o
);

    localparam int unsigned max_dim_lp   = (array_height_p > array_width_p) ?
                                           array_height_p : array_width_p;
    localparam int unsigned last_step_lp = k_p + max_dim_lp - 2;
    localparam int unsigned step_w_lp    = $clog2(last_step_lp + 2);
    localparam logic [step_w_lp-1:0] last_step_c = step_w_lp'(last_step_lp);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

    state_e                                            state_q;
    logic [step_w_lp-1:0]                              step_q;
    logic [array_height_p-1:0]                         flush_q;
    logic [width_p*array_height_p*k_p-1:0]             a_q;
    logic [width_p*k_p*array_width_p-1:0]              b_q;
    logic [width_p*array_height_p*array_width_p-1:0]   result_q;
    logic                                              z_all_v;
    logic                                              feed_fire;

`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
    localparam int unsigned cnt_w_lp = $clog2(timeout_p + 1);
    localparam logic [cnt_w_lp-1:0] cnt_last_c = cnt_w_lp'(timeout_p - 1);
    logic [cnt_w_lp-1:0] cnt_q;
    logic                error_q;
`endif

    assign z_all_v       = &z_v_i;
    assign start_ready_o = (state_q == StIdle);
    assign done_v_o      = (state_q == StDone);
    assign flush_o       = flush_q;
    assign result_o      = result_q;
    assign z_yumi_o      = (state_q == StDrain && z_all_v) ? '1 : '0;

    // Lane r (or c) carries element k = step - lane while that index lies inside 0..K-1.
    always_comb begin
        row_v_o = '0;
        row_o   = '0;
        col_v_o = '0;
        col_o   = '0;
        if (state_q == StFeed) begin
            for (int r = 0; r < int'(array_height_p); r++) begin
                if (int'(step_q) >= r && int'(step_q) - r < int'(k_p)) begin
                    row_v_o[r] = 1'b1;
                    row_o[r*width_p +: width_p] =
                        a_q[(r*int'(k_p) + int'(step_q) - r)*width_p +: width_p];
                end
            end
            for (int c = 0; c < int'(array_width_p); c++) begin
                if (int'(step_q) >= c && int'(step_q) - c < int'(k_p)) begin
                    col_v_o[c] = 1'b1;
                    col_o[c*width_p +: width_p] =
                        b_q[((int'(step_q) - c)*int'(array_width_p) + c)*width_p +: width_p];
                end
            end
        end
    end

    assign feed_fire = ((row_v_o & ~row_ready_i) == '0) && ((col_v_o & ~col_ready_i) == '0);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= StIdle;
            step_q   <= '0;
            flush_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
            cnt_q    <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            flush_q <= '0;
            case (state_q)
                StIdle: begin
                    if (start_v_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        flush_q <= '1;
                        step_q  <= '0;
                        state_q <= StFeed;
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
                        error_q <= 1'b0;
`endif
                    end
                end
                StFeed: begin
                    if (feed_fire) begin
                        if (step_q == last_step_c) begin
                            state_q <= StDrain;
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end else begin
                            step_q <= step_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (z_all_v) begin
                        result_q <= z_i;
                        state_q  <= StDone;
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
                    end else if (cnt_q == cnt_last_c) begin
                        result_q <= z_i;
                        error_q  <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                StDone: begin
                    if (done_yumi_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: 2x2 and 3x3 jobs, stalls, reset abort, DONE hold, drain wait.
module tb_systolic_feeder;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    // 2x2, K=2 instance
    logic [127:0] a2, b2, z2_i, result2;
    logic         start_v2, start_ready2, done_v2, done_yumi2, error2;
    logic [1:0]   flush2, row_v2, row_ready2, col_v2, col_ready2;
    logic [63:0]  row2, col2;
    logic [3:0]   z_v2, z_yumi2;

    // 3x3, K=3 instance
    logic [287:0] a3, b3, z3_i, result3;
    logic         start_v3, start_ready3, done_v3, done_yumi3, error3;
    logic [2:0]   flush3, row_v3, row_ready3, col_v3, col_ready3;
    logic [95:0]  row3, col3;
    logic [8:0]   z_v3, z_yumi3;

    int checks = 0;
    int errors = 0;

    systolic_feeder #(
        .width_p(32), .array_width_p(2), .array_height_p(2), .k_p(2), .timeout_p(8)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .a_i(a2), .b_i(b2),
        .start_v_i(start_v2), .start_ready_o(start_ready2), .flush_o(flush2),
        .row_o(row2), .row_v_o(row_v2), .row_ready_i(row_ready2),
        .col_o(col2), .col_v_o(col_v2), .col_ready_i(col_ready2),
        .z_i(z2_i), .z_v_i(z_v2), .z_yumi_o(z_yumi2),
        .result_o(result2), .done_v_o(done_v2), .done_yumi_i(done_yumi2), .error_o(error2)
    );

    systolic_feeder #(
        .width_p(32), .array_width_p(3), .array_height_p(3), .k_p(3), .timeout_p(64)
    ) dut3 (
        .clk_i(clk), .reset_i(reset_i), .a_i(a3), .b_i(b3),
        .start_v_i(start_v3), .start_ready_o(start_ready3), .flush_o(flush3),
        .row_o(row3), .row_v_o(row_v3), .row_ready_i(row_ready3),
        .col_o(col3), .col_v_o(col_v3), .col_ready_i(col_ready3),
        .z_i(z3_i), .z_v_i(z_v3), .z_yumi_o(z_yumi3),
        .result_o(result3), .done_v_o(done_v3), .done_yumi_i(done_yumi3), .error_o(error3)
    );

    localparam logic [127:0] Z2 = {32'd81, 32'd1092, 32'd162, 32'd2069};

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_feed2(input string tag, input logic [1:0] rv, input logic [1:0] cv,
                               input logic [31:0] r1, input logic [31:0] r0,
                               input logic [31:0] c1, input logic [31:0] c0);
        check(tag, {row_v2, col_v2, row2, col2}, {rv, cv, r1, r0, c1, c0});
    endtask

    task automatic check_reset2(input string tag);
        check(tag, {start_ready2, flush2, row_v2, col_v2, row2, col2, z_yumi2, done_v2,
                    result2, error2},
              {1'b1, 2'b00, 2'b00, 2'b00, 64'd0, 64'd0, 4'd0, 1'b0, 128'd0, 1'b0});
    endtask

    task automatic start_job2;
        start_v2 = 1'b1;
        tick();
        start_v2 = 1'b0;
        check("flush_pulse", {flush2, start_ready2}, 3'b110);
    endtask

    task automatic feed_job2;
        check_feed2("step0", 2'b01, 2'b01, 32'd0, 32'd13, 32'd0, 32'd83);
        tick();
        check("flush_one_cycle", {30'd0, flush2}, 32'd0);
        check_feed2("step1", 2'b11, 2'b11, 32'd6, 32'd45, 32'd9, 32'd22);
        tick();
        check_feed2("step2", 2'b10, 2'b10, 32'd27, 32'd0, 32'd1, 32'd0);
        tick();
        check_feed2("drain_idle_lanes", 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic drain_job2;
        z2_i = Z2;
        z_v2 = 4'hf;
        #1;
        check("z_yumi", {28'd0, z_yumi2}, 32'hf);
        tick();
        z_v2 = 4'h0;
        check("done_result", {done_v2, error2, z_yumi2, result2}, {1'b1, 1'b0, 4'd0, Z2});
        done_yumi2 = 1'b1;
        tick();
        done_yumi2 = 1'b0;
        check("back_idle", {start_ready2, done_v2}, 2'b10);
    endtask

    initial begin
        int a3m [3][3];
        int b3m [3][3];
        int z3m [3][3];
        logic [2:0] rv3 [5];
        int n;
        logic yumi_seen;

        a3m = '{'{70, -17, -43}, '{-58, -7, 40}, '{61, -14, -5}};
        b3m = '{'{-7, 43, -99}, '{30, 98, -93}, '{-8, 91, -31}};
        z3m = '{'{-656, -2569, -4016}, '{-124, 460, 5153}, '{-807, 796, -4582}};
        rv3 = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100};

        reset_i = 1'b0;
        a2 = {32'd27, 32'd6, 32'd45, 32'd13};
        b2 = {32'd1, 32'd22, 32'd9, 32'd83};
        z2_i = '0; z_v2 = '0; start_v2 = 1'b0; done_yumi2 = 1'b0;
        row_ready2 = 2'b11; col_ready2 = 2'b11;
        a3 = '0; b3 = '0; z3_i = '0; z_v3 = '0; start_v3 = 1'b0; done_yumi3 = 1'b0;
        row_ready3 = 3'b111; col_ready3 = 3'b111;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                a3[(r*3+k)*32 +: 32] = 32'(a3m[r][k]);
                b3[(r*3+k)*32 +: 32] = 32'(b3m[r][k]);
                z3_i[(r*3+k)*32 +: 32] = 32'(z3m[r][k]);
            end
        end

        tick();
        tick();
        reset_i = 1'b1;
        check_reset2("reset_values");

        // Basic job with readies held high
        start_job2();
        feed_job2();
        drain_job2();

        // Row 1 not ready for three cycles at step 1
        start_job2();
        check_feed2("stall_step0", 2'b01, 2'b01, 32'd0, 32'd13, 32'd0, 32'd83);
        tick();
        row_ready2 = 2'b01;
        check_feed2("stall_c1", 2'b11, 2'b11, 32'd6, 32'd45, 32'd9, 32'd22);
        tick();
        check_feed2("stall_c2", 2'b11, 2'b11, 32'd6, 32'd45, 32'd9, 32'd22);
        tick();
        check_feed2("stall_c3", 2'b11, 2'b11, 32'd6, 32'd45, 32'd9, 32'd22);
        tick();
        row_ready2 = 2'b11;
        check_feed2("stall_c4", 2'b11, 2'b11, 32'd6, 32'd45, 32'd9, 32'd22);
        tick();
        check_feed2("stall_step2", 2'b10, 2'b10, 32'd27, 32'd0, 32'd1, 32'd0);
        tick();
        drain_job2();

        // Reset aborts mid-feed, next job runs clean
        start_job2();
        tick();
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        check_reset2("reset_mid_feed");
        start_job2();
        feed_job2();
        drain_job2();

        // DONE held while start_v is asserted
        start_job2();
        feed_job2();
        z2_i = Z2;
        z_v2 = 4'hf;
        tick();
        z_v2 = 4'h0;
        start_v2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("done_hold", {start_ready2, flush2, done_v2, result2},
                  {1'b0, 2'b00, 1'b1, Z2});
        end
        start_v2 = 1'b0;
        done_yumi2 = 1'b1;
        tick();
        done_yumi2 = 1'b0;
        check("hold_release", {start_ready2, done_v2}, 2'b10);

        // Drain with a partial z_v
        start_job2();
        feed_job2();
        z2_i = Z2;
        z_v2 = 4'b0111;
`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
        n = 0;
        yumi_seen = 1'b0;
        while (n < 40 && !done_v2) begin
            if (z_yumi2 != 4'd0) yumi_seen = 1'b1;
            tick();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd8);
        check("timeout_outputs", {done_v2, error2, yumi_seen, z_yumi2, result2},
              {1'b1, 1'b1, 1'b0, 4'd0, Z2});
        z_v2 = 4'h0;
        done_yumi2 = 1'b1;
        tick();
        done_yumi2 = 1'b0;
        check("timeout_release", {start_ready2, done_v2}, 2'b10);
`else
        n = 0;
        yumi_seen = 1'b0;
        while (n < 20) begin
            if (z_yumi2 != 4'd0) yumi_seen = 1'b1;
            tick();
            n++;
        end
        check("drain_waits", {done_v2, error2, yumi_seen}, 3'b000);
        drain_job2();
`endif

        // 3x3 job, K=3
        start_v3 = 1'b1;
        tick();
        start_v3 = 1'b0;
        check("flush3", {flush3, start_ready3}, 4'b1110);
        for (int s = 0; s < 5; s++) begin
            check($sformatf("valid3_step%0d", s), {row_v3, col_v3}, {rv3[s], rv3[s]});
            if (s == 2) begin
                check("row3_step2", row3, {32'd61, 32'(-7), 32'(-43)});
                check("col3_step2", col3, {32'(-99), 32'd98, 32'(-8)});
            end
            tick();
        end
        check("drain3_idle_lanes", {row_v3, col_v3}, 6'd0);
        z_v3 = 9'h1ff;
        #1;
        check("z_yumi3", {23'd0, z_yumi3}, 32'h1ff);
        tick();
        z_v3 = 9'h0;
        check("result3_row0", result3[95:0], {32'(-4016), 32'(-2569), 32'(-656)});
        check("result3_full", {done_v3, error3, result3[287:96]},
              {1'b1, 1'b0, 32'(-4582), 32'd796, 32'(-807), 32'd5153, 32'd460, 32'(-124)});
        done_yumi3 = 1'b1;
        tick();
        done_yumi3 = 1'b0;
        check("back_idle3", {start_ready3, done_v3}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter width_p, 32, element width in bits (two's complement).
REQ-002 Parameter array_width_p, 2, array columns (W).
REQ-003 Parameter array_height_p, 2, array rows (H).
REQ-004 Parameter k_p, 2, inner dimension K of A(HxK) x B(KxW).
REQ-005 Parameter timeout_p, 64, drain watchdog limit in cycles (used only with REQ-030).
REQ-006 clk_i  in  1  sole clock, all state changes on rising edge.
REQ-007 reset_i  in  1  reset, synchronous and active-low.
REQ-008 a_i  in  width_p*H*K  matrix A, element (r,k) at slice r*K+k.
REQ-009 b_i  in  width_p*K*W  matrix B, element (k,c) at slice k*W+c.
REQ-010 start_v_i / start_ready_o  in/out  1/1  job-start valid/ready handshake.
REQ-011 flush_o  out  H  clears array accumulators.
REQ-012 row_o, row_v_o, row_ready_i  out/out/in  width_p*H, H, H  array row feed.
REQ-013 col_o, col_v_o, col_ready_i  out/out/in  width_p*W, W, W  array column feed.
REQ-014 z_i, z_v_i, z_yumi_o  in/in/out  width_p*H*W, H*W, H*W  array results.
REQ-015 result_o, done_v_o, done_yumi_i  out/out/in  width_p*H*W, 1, 1  captured result, valid-then-yumi.
REQ-016 error_o  out  1  result produced by watchdog expiry, valid with done_v_o.

Function
REQ-017 FSM states IDLE, FEED, DRAIN, DONE; start_ready_o = 1 only in IDLE.
REQ-018 IDLE: start_v_i & start_ready_o registers a_i and b_i, pulses flush_o all-ones for exactly one cycle, clears step s to 0, enters FEED.
REQ-019 FEED, step s: row r valid iff 0 <= s-r < K, row_o[r] = A(r, s-r); column c valid iff 0 <= s-c < K, col_o[c] = B(s-c, c); invalid lanes drive 0.
REQ-020 Step advances only on a cycle where row_ready_i covers every set row_v_o bit and col_ready_i covers every set col_v_o bit; otherwise all feed outputs hold stable.
REQ-021 Last step is S = K + max(H,W) - 2; advancing from S enters DRAIN with all row_v_o/col_v_o low.
REQ-022 Step counter width $clog2(S+2); no wrap occurs within a job.
REQ-023 DRAIN: z_yumi_o = all-ones on the first cycle z_v_i is all-ones; that cycle captures z_i verbatim into result_o and enters DONE.
REQ-024 DONE: done_v_o = 1, result_o stable; done_yumi_i returns to IDLE; start_v_i is ignored until then.
REQ-025 No arithmetic performed; data passes bit-exact.

Reset
REQ-026 reset_i low at a rising edge forces IDLE regardless of state, including mid-FEED and mid-DRAIN.
REQ-027 Outputs after reset: start_ready_o=1, flush_o=0, row_v_o=0, col_v_o=0, row_o=0, col_o=0, z_yumi_o=0, done_v_o=0, result_o=0, error_o=0.
REQ-028 Reset aborts a job without driving flush_o; the next accepted start flushes.

Configuration
REQ-029 Macro SYSTOLIC_FEEDER_TIMEOUT_EN selects the drain watchdog.
REQ-030 Defined: cycle counter runs in DRAIN; reaching timeout_p without full z_v_i enters DONE with result_o = z_i as sampled, z_yumi_o = 0, error_o = 1.
REQ-031 Undefined: no counter, DRAIN waits indefinitely, error_o tied 0.

Verification
REQ-032 2x2, K=2, A={13,45;6,27}, B={83,9;22,1}, readies held 1, ideal array model -> steps: row_v/col_v 01,11,10; result (0,0)=2069,(0,1)=162,(1,0)=1092,(1,1)=81; error_o=0.
REQ-033 Same job, row_ready_i[1]=0 for 3 cycles at step 1 -> step 1 outputs held 4 cycles, identical final result.
REQ-034 reset_i low one cycle during step 1 -> all REQ-027 values next cycle; new start completes correctly.
REQ-035 DONE held with done_yumi_i=0 for 10 cycles, start_v_i=1 -> start_ready_o=0, result_o unchanged, no flush_o pulse.
REQ-036 TIMEOUT_EN defined, timeout_p=8, z_v_i never all-ones -> done_v_o 8 cycles after DRAIN entry, error_o=1, z_yumi_o never asserted.
REQ-037 3x3, K=3, A={70,-17,-43;-58,-7,40;61,-14,-5}, B={-7,43,-99;30,98,-93;-8,91,-31} -> 5 feed steps, result row 0 = -656,-2569,-4016.
